// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes and FSM state type for the load/store unit
package lsu_pkg;

  // load width/sign codes
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  // store width codes
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WB,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/lsu_wb_if.sv
// rtl/lsu_wb_if.sv - req/ack data-memory port between the LSU and memory
interface lsu_wb_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - combinational byte-lane steering, load extract and access checks
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_load,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] load_data,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_rdata[{off, 3'b000} +: 8];
  assign half_sel = mem_rdata[{off[1], 4'b0000} +: 16];

  // halfword needs an even address, word needs a 4-byte aligned one
  assign misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                      ((funct3[1:0] == 2'b10) && (off != 2'b00));

  assign illegal = is_load ? ((funct3 == 3'd3) || (funct3[2:1] == 2'b11))
                           : (funct3 >= 3'd3);

  // loads extract from the returned word; stores replicate data across lanes
  always_comb begin
    load_data = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (is_load) begin
      case (funct3)
        LB:      load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        LBU:     load_data = {{(XLEN-8){1'b0}}, byte_sel};
        LH:      load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
        LHU:     load_data = {{(XLEN-16){1'b0}}, half_sel};
        LW:      load_data = mem_rdata;
        default: load_data = '0;
      endcase
    end else begin
      case (funct3)
        SB: begin
          mem_wdata = {4{store_data[7:0]}};
          mem_be    = 4'b0001 << off;
        end
        SH: begin
          mem_wdata = {2{store_data[15:0]}};
          mem_be    = 4'b0011 << off;
        end
        SW: begin
          mem_wdata = store_data;
          mem_be    = 4'b1111;
        end
        default: begin
          mem_wdata = '0;
          mem_be    = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lsu_wb.sv
// rtl/lsu_wb.sv - multi-cycle load/store unit driving the register-file write port
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  output logic             ready,
  input  logic             is_load,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  store_data,
  input  logic [RADDR-1:0] rd,
  lsu_wb_if.master         bus,
  output logic [XLEN-1:0]  dataW,
  output logic [RADDR-1:0] rsW,
  output logic             RegWen,
  output logic             done,
  output logic             err
);

  // at least one bit so TIMEOUT=0 still elaborates
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state;
  logic             is_load_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic [RADDR-1:0] rd_q;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;

  logic             lane_is_load;
  logic [2:0]       lane_funct3;
  logic [1:0]       lane_off;
  logic [XLEN-1:0]  lane_load;
  logic [3:0]       lane_be;
  logic [XLEN-1:0]  lane_wdata;
  logic             lane_misaligned;
  logic             lane_illegal;

  assign ready    = (state == IDLE);
  assign cnt_next = cnt + 1'b1;

  // while idle the lane checks the incoming op; afterwards it decodes the captured one
  assign lane_is_load = ready ? is_load    : is_load_q;
  assign lane_funct3  = ready ? funct3     : funct3_q;
  assign lane_off     = ready ? addr[1:0]  : off_q;

  lsu_lane #(.XLEN(XLEN)) u_lane (
    .is_load    (lane_is_load),
    .funct3     (lane_funct3),
    .off        (lane_off),
    .store_data (store_data),
    .mem_rdata  (bus.mem_rdata),
    .load_data  (lane_load),
    .mem_be     (lane_be),
    .mem_wdata  (lane_wdata),
    .misaligned (lane_misaligned),
    .illegal    (lane_illegal)
  );

  // FSM with all memory and write-back outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      is_load_q     <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      dataW         <= '0;
      rsW           <= '0;
      RegWen        <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      RegWen <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            is_load_q <= is_load;
            funct3_q  <= funct3;
            off_q     <= addr[1:0];
            rd_q      <= rd;
            if (lane_misaligned || lane_illegal) begin
              state <= ERR;
              err   <= 1'b1;
              done  <= 1'b1;
            end else begin
              state         <= REQ;
              cnt           <= '0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= ~is_load;
              bus.mem_addr  <= {addr[XLEN-1:2], 2'b00};
              bus.mem_be    <= lane_be;
              bus.mem_wdata <= lane_wdata;
            end
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            done          <= 1'b1;
            if (is_load_q) begin
              state  <= WB;
              RegWen <= (rd_q != '0);
              rsW    <= rd_q;
              dataW  <= lane_load;
            end else begin
              state <= DONE;
            end
          end else begin
            if (cnt != '1) cnt <= cnt_next;
            if ((TIMEOUT > 0) && (cnt_next == CW'(TIMEOUT))) begin
              state         <= ERR;
              bus.mem_req   <= 1'b0;
              bus.mem_we    <= 1'b0;
              bus.mem_be    <= '0;
              bus.mem_wdata <= '0;
              err           <= 1'b1;
              done          <= 1'b1;
            end
          end
        end
        WB, DONE, ERR: state <= IDLE;
        default:       state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb.sv
// tb/tb_lsu_wb.sv - table-driven scoreboard bench for lsu_wb
module tb_lsu_wb;

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          ack_delay;
    logic        e_err;
    int          e_wen;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    int          e_req;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic        is_load = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd = '0;
  logic [31:0] dataW;
  logic [4:0]  rsW;
  logic        RegWen;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  vec_t sb_q[$];
  vec_t vecs[15];

  lsu_wb_if #(.XLEN(32)) bus ();

  lsu_wb #(.XLEN(32), .RADDR(5), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .ready      (ready),
    .is_load    (is_load),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd         (rd),
    .bus        (bus),
    .dataW      (dataW),
    .rsW        (rsW),
    .RegWen     (RegWen),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] s, input logic [4:0] r, input logic [31:0] rdt,
                              input int dly, input logic ee, input int ew, input logic [31:0] ed,
                              input logic [3:0] eb, input logic [31:0] ewd, input int erq);
    vec_t v;
    v.is_load = ld; v.f3 = f; v.addr = a; v.sd = s; v.rd = r; v.rdata = rdt;
    v.ack_delay = dly; v.e_err = ee; v.e_wen = ew; v.e_data = ed;
    v.e_be = eb; v.e_wdata = ewd; v.e_req = erq;
    return v;
  endfunction

  // drive one op, answer the memory port, and compare at the done pulse
  task automatic run_op(input int idx, input vec_t v);
    vec_t e;
    int reqc, wenc, cyc;
    bit fin;
    @(negedge clk);
    valid = 1'b1; is_load = v.is_load; funct3 = v.f3; addr = v.addr;
    store_data = v.sd; rd = v.rd;
    sb_q.push_back(v);
    @(negedge clk);
    valid = 1'b0;
    reqc = 0; wenc = 0; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 64) begin
      bus.mem_ack = 1'b0;
      if (RegWen) wenc++;
      if (done) begin
        fin = 1'b1;
        e = sb_q.pop_front();
        chk($sformatf("v%0d err", idx), {31'b0, err}, {31'b0, e.e_err});
        chk($sformatf("v%0d regwen_cnt", idx), wenc, e.e_wen);
        if (e.e_wen != 0) begin
          chk($sformatf("v%0d dataW", idx), dataW, e.e_data);
          chk($sformatf("v%0d rsW", idx), {27'b0, rsW}, {27'b0, e.rd});
        end
        chk($sformatf("v%0d req_cycles", idx), reqc, e.e_req);
        chk($sformatf("v%0d req_dropped", idx), {31'b0, bus.mem_req}, 32'd0);
        chk($sformatf("v%0d ready_busy", idx), {31'b0, ready}, 32'd0);
      end else if (bus.mem_req) begin
        reqc++;
        if (reqc == 1) begin
          chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.addr & 32'hFFFF_FFFC);
          chk($sformatf("v%0d mem_we", idx), {31'b0, bus.mem_we}, {31'b0, ~v.is_load});
          chk($sformatf("v%0d mem_be", idx), {28'b0, bus.mem_be}, {28'b0, v.e_be});
          chk($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.e_wdata);
        end
        if (v.ack_delay >= 0 && reqc == v.ack_delay + 1) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = v.rdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL v%0d done_wait actual=none required=done within 64 cycles", idx);
      void'(sb_q.pop_front());
    end else begin
      chk($sformatf("v%0d ready_after", idx), {31'b0, ready}, 32'd1);
      chk($sformatf("v%0d done_pulse", idx), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d regwen_pulse", idx), {31'b0, RegWen}, 32'd0);
    end
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;

    //        ld f3    addr          sd            rd  rdata         dly err wen data          be       wdata         req
    vecs[0]  = mk(1, 3'd0, 32'h0000_0103, 32'h0,         5, 32'h80FF_1234, 2, 0, 1, 32'hFFFF_FF80, 4'b0000, 32'h0,         3);
    vecs[1]  = mk(0, 3'd1, 32'h0000_0022, 32'hDEAD_BEEF, 0, 32'h0,         1, 0, 0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 2);
    vecs[2]  = mk(1, 3'd2, 32'h0000_0041, 32'h0,         4, 32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0,         0);
    vecs[3]  = mk(1, 3'd5, 32'h0000_0002, 32'h0,         0, 32'h8001_0000, 0, 0, 0, 32'h0,         4'b0000, 32'h0,         1);
    vecs[4]  = mk(1, 3'd1, 32'h0000_0002, 32'h0,         7, 32'h8001_0000, 0, 0, 1, 32'hFFFF_8001, 4'b0000, 32'h0,         1);
    vecs[5]  = mk(1, 3'd4, 32'h0000_0001, 32'h0,         3, 32'h0000_9A00, 1, 0, 1, 32'h0000_009A, 4'b0000, 32'h0,         2);
    vecs[6]  = mk(1, 3'd2, 32'h0000_1000, 32'h0,        31, 32'h1234_5678, 3, 0, 1, 32'h1234_5678, 4'b0000, 32'h0,         4);
    vecs[7]  = mk(0, 3'd0, 32'h0000_0007, 32'h0000_00A5, 0, 32'h0,         0, 0, 0, 32'h0,         4'b1000, 32'hA5A5_A5A5, 1);
    vecs[8]  = mk(0, 3'd2, 32'h0000_0008, 32'hCAFE_F00D, 0, 32'h0,         2, 0, 0, 32'h0,         4'b1111, 32'hCAFE_F00D, 3);
    vecs[9]  = mk(1, 3'd3, 32'h0000_0000, 32'h0,         2, 32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0,         0);
    vecs[10] = mk(0, 3'd4, 32'h0000_0000, 32'h1,         0, 32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0,         0);
    vecs[11] = mk(0, 3'd2, 32'h0000_000A, 32'h1,         0, 32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0,         0);
    vecs[12] = mk(1, 3'd1, 32'h0000_0003, 32'h0,         6, 32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0,         0);
    vecs[13] = mk(1, 3'd6, 32'h0000_0000, 32'h0,         6, 32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0,         0);
    vecs[14] = mk(1, 3'd2, 32'h0000_0200, 32'h0,         8, 32'h0,        -1, 1, 0, 32'h0,         4'b0000, 32'h0,        16);

    // reset state
    #12;
    chk("rst ready", {31'b0, ready}, 32'd1);
    chk("rst mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst RegWen", {31'b0, RegWen}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst dataW", dataW, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_op(i, vecs[i]);

    // reset mid-transaction, then a stray ack must not write back
    @(negedge clk);
    valid = 1'b1; is_load = 1'b1; funct3 = 3'd2; addr = 32'h300; rd = 5'd9;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("mid req_high", {31'b0, bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid req_drop", {31'b0, bus.mem_req}, 32'd0);
    chk("mid ready", {31'b0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stray RegWen%0d", k), {31'b0, RegWen}, 32'd0);
      chk($sformatf("stray done%0d", k), {31'b0, done}, 32'd0);
    end
    bus.mem_ack = 1'b0;

    // the unit still works after the aborted op
    run_op(15, vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Multi-cycle load/store unit with a req/ack data-memory port.
- Sits directly upstream of the register file write port: drives dataW, rsW and RegWen.
- Accepts one memory op from execute (ALU-computed address), aligns and sign-extends load data, and issues a single-cycle write-back pulse.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- XLEN, 32, data/address width.
- RADDR, 5, register index width.
- TIMEOUT, 16, max cycles waiting for mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  op request from execute.
- ready  out  1  high in IDLE; op accepted on valid && ready.
- is_load  in  1  1 = load, 0 = store.
- funct3  in  3  RV32I width/sign code.
- addr  in  XLEN  byte address.
- store_data  in  XLEN  rs2 value.
- rd  in  RADDR  load destination.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  store strobe.
- mem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_ack  in  1  memory completion.
- mem_rdata  in  XLEN  read data, valid with mem_ack.
- dataW  out  XLEN  write-back data to register file.
- rsW  out  RADDR  write-back index.
- RegWen  out  1  write-back enable, one-cycle pulse.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle fault pulse, coincident with done.

Behaviour:
- Reset (async, rst_n=0): state IDLE; ready=1; all other outputs 0; timeout counter 0. Reset mid-transaction drops mem_req immediately; no write-back occurs.
- All outputs are registered except ready, which is decoded from state.
- States: IDLE, REQ, WB, DONE, ERR.
- IDLE:
  - On valid, capture all inputs.
  - Go to ERR if misaligned (halfword with addr[0]=1; word with addr[1:0]!=0) or funct3 is illegal (load 3/6/7; store >=3).
  - Otherwise go to REQ.
  - valid is ignored when not in IDLE.
- REQ:
  - mem_req=1 with stable mem_addr/mem_we/mem_be/mem_wdata for as long as the state persists.
  - mem_ack sampled high with a load: latch the extracted data and go to WB.
  - mem_ack sampled high with a store: go to DONE.
  - Counter increments each REQ cycle. If TIMEOUT>0 and the count reaches TIMEOUT without ack, go to ERR; mem_req drops.
- WB: RegWen=(rd!=0), rsW=rd, dataW=extracted data, done=1; then IDLE.
- DONE: done=1, RegWen=0; then IDLE.
- ERR: err=1, done=1, RegWen=0, no memory access; then IDLE.
- mem_ack outside REQ is ignored.
- Latency: accept at cycle N; mem_req high from N+1; ack sampled at cycle M; RegWen/done high at M+1; ready high at M+2. Minimum load is 3 cycles accept-to-ready.
- Load extract (off=addr[1:0]):
  - LB: sign-extend byte at [8*off+7 : 8*off].
  - LBU: zero-extend the same byte.
  - LH: sign-extend half at addr[1] (bits [16*addr[1]+15 : 16*addr[1]]).
  - LHU: zero-extend the same half.
  - LW: full word.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, be=4'b0001<<off.
  - SH: wdata={2{sd[15:0]}}, be=4'b0011<<off.
  - SW: wdata=sd, be=4'b1111.
- mem_be=0 and mem_wdata=0 for loads.
- Timeout counter: clog2(TIMEOUT+1) bits; cleared on entry to REQ; no wrap.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
  - State enum: IDLE, REQ, WB, DONE, ERR.
- Sub-module lsu_lane: purely combinational. Inputs funct3, off, store_data, mem_rdata; outputs load_data, mem_be, mem_wdata, misaligned, illegal. lsu_wb holds the FSM, counter and output registers.

Test Plan:
- Load, rd=5, LB, addr=0x103, mem_rdata=0x80FF_1234 with ack 2 cycles after mem_req -> mem_addr=0x100, RegWen one cycle with dataW=0xFFFF_FF80, rsW=5; done coincident.
- Store, SH, addr=0x22, store_data=0xDEAD_BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x20; done after ack; RegWen never asserts.
- Load, LW, addr=0x41 -> no mem_req; err and done pulse one cycle; ready high again 2 cycles after accept.
- Load, LHU, rd=0, addr=0x2, mem_rdata=0x8001_0000 -> done pulses, RegWen stays 0.
- Load with mem_ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles, then err=1, RegWen=0.
- rst_n low while in REQ -> mem_req=0 immediately; after release ready=1, and a later stray mem_ack produces no RegWen.
